// File: rtl/cla_byte_sequencer.sv
// cla_byte_sequencer
// Byte-serial wide-operand add/subtract sequencer built around an external
// 8-bit carry-lookahead adder. Operands are fed to the adder LSB-first, one byte
// per cycle. The adder's carry-out is chained into the next byte's carry-in.
// The assembled sum, carry-out and signed overflow are returned on a valid/ready
// port.
//
// state  | meaning
// -------+-------------------------------------------------------------------
// S_IDLE | ready for a request; adder inputs parked at zero
// S_RUN  | one byte per cycle through the adder; r_idx selects the byte
// S_DONE | result held on sum/cout/ovf with out_valid high until taken

module cla_byte_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic                op_cin,
    input  logic                sub,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_cin,
    input  logic [7:0]          add_s,
    input  logic                add_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;
    logic [7:0]      r_add_a;
    logic [7:0]      r_add_b;
    logic            r_add_cin;
    logic            r_in_ready;
    logic            r_out_valid;

    logic            w_accept;
    logic            w_release;
    logic            w_last;
    logic [IW-1:0]   w_idx_nxt;
    logic [W-1:0]    w_b_eff;
    logic [7:0]      w_a_next_byte;
    logic [7:0]      w_b_next_byte;
    logic            w_ovf;

    assign w_accept  = in_valid & r_in_ready;
    assign w_release = r_out_valid & out_ready;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_idx_nxt = r_idx + 1'b1;

    // Subtraction is A + ~B + 1, so B is inverted once at accept time.
    assign w_b_eff = sub ? ~op_b : op_b;

    // Byte that the adder sees in the next RUN cycle. Only used on non-final
    // edges, so w_idx_nxt stays within the operand.
    assign w_a_next_byte = r_a[{w_idx_nxt, 3'b000} +: 8];
    assign w_b_next_byte = r_b[{w_idx_nxt, 3'b000} +: 8];

    // Signed overflow: both addends share a sign and the top result byte's MSB
    // differs from it. r_b already holds the effective (possibly inverted) B.
    assign w_ovf = (r_a[W-1] == r_b[W-1]) && (add_s[7] != r_a[W-1]);

    // Sequencer FSM. The adder inputs are registered and always present the
    // byte that belongs to the current RUN cycle. r_add_cin doubles as the
    // chained carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_add_a     <= 8'h00;
            r_add_b     <= 8'h00;
            r_add_cin   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a        <= op_a;
                        r_b        <= w_b_eff;
                        r_sum      <= '0;
                        r_idx      <= '0;
                        r_add_a    <= op_a[7:0];
                        r_add_b    <= w_b_eff[7:0];
                        r_add_cin  <= sub ? 1'b1 : op_cin;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_sum[{r_idx, 3'b000} +: 8] <= add_s;
                    if (w_last) begin
                        r_cout      <= add_cout;
                        r_ovf       <= w_ovf;
                        r_add_a     <= 8'h00;
                        r_add_b     <= 8'h00;
                        r_add_cin   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx     <= w_idx_nxt;
                        r_add_a   <= w_a_next_byte;
                        r_add_b   <= w_b_next_byte;
                        r_add_cin <= add_cout;
                    end
                end

                S_DONE: begin
                    // Result holds until taken; in_valid is ignored here, so a
                    // new request can only land the cycle after the handshake.
                    if (w_release) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_add_a     <= 8'h00;
                    r_add_b     <= 8'h00;
                    r_add_cin   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_cin   = r_add_cin;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_byte_sequencer.sv
// Directed bench for cla_byte_sequencer (NBYTES=4) with a behavioural 8-bit
// adder standing in for cla_adder.

module tb_cla_byte_sequencer;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_cin;
    logic          sub;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_s;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int n_cmp;
    int n_bad;

    cla_byte_sequencer #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .sub       (sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Combinational 8-bit adder model.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at the next falling edge, wait for out_valid, check the
    // latency and result. If out_ready is high the handshake is also checked.
    task automatic run_op(input string tag,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb,
                          input logic [W-1:0] e_sum, input logic e_cout,
                          input logic e_ovf, input logic [7:0] e_add_a0);
        int cyc;
        @(negedge clk);
        check_val({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        op_a = a; op_b = b; op_cin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a = '1; op_b = '1; op_cin = 1'b1; sub = ~sb;
        check_val({tag, ".in_ready_run"}, 64'(in_ready), 64'd0);
        check_val({tag, ".add_a0"}, 64'(add_a), 64'(e_add_a0));
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check_val({tag, ".latency"}, 64'(cyc), 64'd4);
        check_val({tag, ".sum"}, 64'(sum), 64'(e_sum));
        check_val({tag, ".cout"}, 64'(cout), 64'(e_cout));
        check_val({tag, ".ovf"}, 64'(ovf), 64'(e_ovf));
        check_val({tag, ".add_cin_done"}, 64'(add_cin), 64'd0);
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
            check_val({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
            check_val({tag, ".ready_back"}, 64'(in_ready), 64'd1);
            check_val({tag, ".sum_kept"}, 64'(sum), 64'(e_sum));
        end
    endtask

    initial begin
        int seen;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;

        #12;
        check_val("rst.in_ready", 64'(in_ready), 64'd1);
        check_val("rst.out_valid", 64'(out_valid), 64'd0);
        check_val("rst.sum", 64'(sum), 64'd0);
        check_val("rst.add", 64'({add_a, add_b, add_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 8'hFF);
        run_op("t2", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'hFF);
        run_op("t3", 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 8'hFF);
        run_op("t4a", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 8'h05);
        run_op("t4b", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 8'h00);

        // Back-pressure: result must hold and new requests must be refused.
        out_ready = 1'b0;
        run_op("t5", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 8'h78);
        for (int i = 0; i < 3; i++) begin
            op_a = 32'hDEADBEEF; op_b = 32'h01010101; sub = 1'b0; op_cin = 1'b1;
            in_valid = (i != 1);
            @(posedge clk);
            @(negedge clk);
            check_val("t5.hold_valid", 64'(out_valid), 64'd1);
            check_val("t5.hold_ready", 64'(in_ready), 64'd0);
            check_val("t5.hold_sum", 64'(sum), 64'h23456789);
            check_val("t5.hold_flags", 64'({cout, ovf}), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("t5.release_valid", 64'(out_valid), 64'd0);
        check_val("t5.release_ready", 64'(in_ready), 64'd1);
        check_val("t5.release_sum", 64'(sum), 64'h23456789);
        run_op("t5n", 32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'h00);

        // Reset after two RUN cycles aborts the operation.
        @(negedge clk);
        op_a = 32'h01020304; op_b = 32'h10203040; op_cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("t6.run_add_a1", 64'(add_a), 64'h03);
        rst_n = 1'b0;
        #1;
        check_val("t6.rst_ready", 64'(in_ready), 64'd1);
        check_val("t6.rst_sum", 64'(sum), 64'd0);
        check_val("t6.rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_val("t6.no_valid", 64'(seen), 64'd0);
        run_op("t6n", 32'h000000AA, 32'h00000055, 1'b0, 1'b0, 32'h000000FF, 1'b0, 1'b0, 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
